// File: rtl/kypd_pkg.sv
// Purpose: shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a pure lookup function only).
// Backpressure: n/a.
package kypd_pkg;

    // Debounce FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } kypd_state_t;

    // Per-frame classification, saturating at "two or more"
    typedef enum logic [1:0] {
        FRM_NONE  = 2'd0,
        FRM_ONE   = 2'd1,
        FRM_MULTI = 2'd2
    } frame_res_t;

    // Column drive value out of reset: leftmost column active
    localparam logic [3:0] COL_RESET = 4'b1110;

    // Key legend, nibble index {row, col}; nibble 0 is row0/col0
    localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// Purpose: scan divider, walking-zero column drive and 2-flop row synchronizer.
// Latency: tick every SCAN_DIV cycles; row_sync lags ROW by 2 cycles.
// Backpressure: none; free-running.
// Ports: CLK/RESET; row (raw, active-low) in; col, tick, frame_done,
//        col_idx (column being sampled this tick), row_sync out.
module kypd_col_scan
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       tick,
    output logic       frame_done,
    output logic [1:0] col_idx,
    output logic [3:0] row_sync
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic [3:0]       row_meta;

    assign tick       = (div_cnt == CNT_MAX);
    assign frame_done = tick && (col == 4'b0111);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Walking zero; anything that is not a single zero is forced back to column 0
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            col <= COL_RESET;
        end else if (tick) begin
            case (col)
                4'b1110: col <= 4'b1101;
                4'b1101: col <= 4'b1011;
                4'b1011: col <= 4'b0111;
                default: col <= COL_RESET;
            endcase
        end
    end

    always_comb begin
        case (col)
            4'b1101: col_idx = 2'd1;
            4'b1011: col_idx = 2'd2;
            4'b0111: col_idx = 2'd3;
            default: col_idx = 2'd0;
        endcase
    end

    // Idle rows read as released (pulled up)
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

endmodule

// File: rtl/kypd_scanner_core.sv
// Purpose: 4x4 keypad scanner with whole-frame debounce and ready/ack code delivery.
// Latency: accept registered on the edge after the DEBOUNCE_SCANS-th matching frame.
// Backpressure: KEY_READY held until KEY_ACK; an unacked code is overwritten and flags OVERRUN.
// Ports: CLK, RESET, ROW in / COL out (keypad); KEY_CODE, KEY_READY, KEY_ACK,
//        KEY_STROBE, KEY_PRESSED, KEY_HIST, OVERRUN (consumer side).
module kypd_scanner_core
    import kypd_pkg::*;
#(
    parameter int CLK_FREQUENCY_HZ = 100000000,
    parameter int SCAN_DIV         = 100000,
    parameter int DEBOUNCE_SCANS   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  ROW,
    output logic [3:0]  COL,
    output logic [3:0]  KEY_CODE,
    output logic        KEY_READY,
    input  logic        KEY_ACK,
    output logic        KEY_STROBE,
    output logic        KEY_PRESSED,
    output logic [15:0] KEY_HIST,
    output logic        OVERRUN
);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || CLK_FREQUENCY_HZ < 1) begin : g_param_err
        $error("kypd_scanner_core: parameter out of legal range");
    end

    localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_SCANS);

    logic       tick;
    logic       frame_done;
    logic [1:0] col_idx;
    logic [3:0] row_sync;

    kypd_col_scan #(.SCAN_DIV(SCAN_DIV)) u_col_scan (
        .CLK        (CLK),
        .RESET      (RESET),
        .row        (ROW),
        .col        (COL),
        .tick       (tick),
        .frame_done (frame_done),
        .col_idx    (col_idx),
        .row_sync   (row_sync)
    );

    // ---- frame accumulation ----
    logic [2:0]  col_hits;
    logic [1:0]  hit_row;
    frame_res_t  acc_res, frm_res;
    logic [3:0]  acc_code, frm_code;

    always_comb begin
        col_hits = '0;
        hit_row  = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync[r]) begin
                col_hits = col_hits + 3'd1;
                hit_row  = 2'(r);
            end
        end
    end

    // Running result including this tick's column; on frame_done this is the frame result
    always_comb begin
        frm_res  = acc_res;
        frm_code = acc_code;
        if (col_hits > 3'd1 || (col_hits == 3'd1 && acc_res != FRM_NONE)) begin
            frm_res = FRM_MULTI;
        end else if (col_hits == 3'd1) begin
            frm_res  = FRM_ONE;
            frm_code = key_lookup(hit_row, col_idx);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_res  <= FRM_NONE;
            acc_code <= '0;
        end else if (frame_done) begin
            acc_res  <= FRM_NONE;
            acc_code <= '0;
        end else if (tick) begin
            acc_res  <= frm_res;
            acc_code <= frm_code;
        end
    end

    // ---- debounce FSM ----
    kypd_state_t state, state_nxt;
    logic [3:0]  db_cnt, db_cnt_nxt, cnt_inc;
    logic [3:0]  cand, cand_nxt;
    logic        accept;

    assign cnt_inc = db_cnt + 4'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= ST_IDLE;
            db_cnt <= '0;
            cand   <= '0;
        end else begin
            state  <= state_nxt;
            db_cnt <= db_cnt_nxt;
            cand   <= cand_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        db_cnt_nxt = db_cnt;
        cand_nxt   = cand;
        accept     = 1'b0;
        if (frame_done) begin
            case (state)
                ST_IDLE: begin
                    if (frm_res == FRM_ONE) begin
                        cand_nxt   = frm_code;
                        db_cnt_nxt = 4'd1;
                        if (DB_TARGET == 4'd1) begin
                            accept    = 1'b1;
                            state_nxt = ST_HELD;
                        end else begin
                            state_nxt = ST_DB_PRESS;
                        end
                    end
                end
                ST_DB_PRESS: begin
                    case (frm_res)
                        FRM_ONE: begin
                            if (frm_code == cand) begin
                                db_cnt_nxt = cnt_inc;
                                if (cnt_inc == DB_TARGET) begin
                                    accept    = 1'b1;
                                    state_nxt = ST_HELD;
                                end
                            end else begin
                                cand_nxt   = frm_code;
                                db_cnt_nxt = 4'd1;
                            end
                        end
                        FRM_NONE: state_nxt = ST_IDLE;
                        default:  ; // chord: hold position until it resolves
                    endcase
                end
                ST_HELD: begin
                    if (frm_res == FRM_NONE) begin
                        db_cnt_nxt = 4'd1;
                        state_nxt  = (DB_TARGET == 4'd1) ? ST_IDLE : ST_DB_RELEASE;
                    end
                end
                default: begin // ST_DB_RELEASE
                    if (frm_res == FRM_NONE) begin
                        db_cnt_nxt = cnt_inc;
                        if (cnt_inc == DB_TARGET) state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_HELD;
                    end
                end
            endcase
        end
    end

    always_comb begin
        KEY_PRESSED = (state == ST_HELD) || (state == ST_DB_RELEASE);
    end

    // ---- handshake and history ----
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            KEY_CODE   <= '0;
            KEY_HIST   <= '0;
            KEY_READY  <= 1'b0;
            KEY_STROBE <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            KEY_STROBE <= accept;
            if (accept) begin
                KEY_CODE  <= frm_code;
                KEY_HIST  <= {KEY_HIST[11:0], frm_code};
                KEY_READY <= 1'b1;
                // Pending code lost unless acked this same cycle (ack also clears the flag)
                if (KEY_READY) OVERRUN <= ~KEY_ACK;
            end else if (KEY_READY && KEY_ACK) begin
                KEY_READY <= 1'b0;
                OVERRUN   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kypd_scanner_core.sv
module tb_kypd_scanner_core;

    localparam int SD = 8;
    localparam int DB = 2;
    localparam int FRAME = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_ack = 1'b0;
    logic        key_strobe;
    logic        key_pressed;
    logic [15:0] key_hist;
    logic        overrun;
    logic [15:0] mask = '0;   // pressed keys, bit index row*4+col
    logic        chk_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int strobes = 0;
    int ready_seen = 0;

    always #5 clk = ~clk;

    kypd_scanner_core #(
        .CLK_FREQUENCY_HZ (100000000),
        .SCAN_DIV         (SD),
        .DEBOUNCE_SCANS   (DB)
    ) dut (
        .CLK         (clk),
        .RESET       (rst),
        .ROW         (row),
        .COL         (col),
        .KEY_CODE    (key_code),
        .KEY_READY   (key_ready),
        .KEY_ACK     (key_ack),
        .KEY_STROBE  (key_strobe),
        .KEY_PRESSED (key_pressed),
        .KEY_HIST    (key_hist),
        .OVERRUN     (overrun)
    );

    // Passive keypad: a pressed key shorts its row to its column
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col[c] && mask[r*4+c]) row[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    function automatic logic [3:0] keycap(input int idx);
        case (idx)
            0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
            4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
            8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
            12: return 4'h0; 13: return 4'hF; 14: return 4'hE; default: return 4'hD;
        endcase
    endfunction

    int          m_edges, m_frames, m_run, m_rel, m_keys;
    logic        m_held, m_ready, m_ovr, m_strobe, m_acc;
    logic [3:0]  m_cand, m_code, m_c;
    logic [15:0] m_hist;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_edges = 0; m_frames = 0; m_run = 0; m_rel = 0;
            m_held = 0; m_ready = 0; m_ovr = 0; m_strobe = 0;
            m_cand = 0; m_code = 0; m_hist = 0;
        end else begin
            m_edges++;
            m_acc = 0;
            if (m_edges % FRAME == 0) begin
                m_frames++;
                m_keys = $countones(mask);
                m_c = 0;
                for (int i = 0; i < 16; i++) if (mask[i]) m_c = keycap(i);
                if (!m_held) begin
                    if (m_keys == 1) begin
                        m_run  = (m_run > 0 && m_c == m_cand) ? m_run + 1 : 1;
                        m_cand = m_c;
                        if (m_run == DB) begin m_acc = 1; m_held = 1; m_rel = 0; end
                    end else if (m_keys == 0) begin
                        m_run = 0;
                    end
                end else if (m_keys == 0) begin
                    m_rel++;
                    if (m_rel == DB) begin m_held = 0; m_run = 0; end
                end else begin
                    m_rel = 0;
                end
            end
            m_strobe = m_acc;
            if (m_acc) begin
                m_code = m_cand;
                m_hist = {m_hist[11:0], m_cand};
                if (m_ready) m_ovr = !key_ack;
                m_ready = 1;
            end else if (m_ready && key_ack) begin
                m_ready = 0;
                m_ovr = 0;
            end
        end
    end

    // ---- per-cycle compare ----
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("col",     int'(col),         int'(4'hF & ~(4'b0001 << ((m_edges / SD) % 4))));
            check("code",    int'(key_code),    int'(m_code));
            check("hist",    int'(key_hist),    int'(m_hist));
            check("ready",   int'(key_ready),   int'(m_ready));
            check("strobe",  int'(key_strobe),  int'(m_strobe));
            check("pressed", int'(key_pressed), int'(m_held));
            check("overrun", int'(overrun),     int'(m_ovr));
        end
    end

    // ---- stimulus helpers ----
    task automatic wait_frames(input int k);
        int target = m_frames + k;
        int budget = k * FRAME + 64;
        while (m_frames < target && budget > 0) begin
            @(negedge clk);
            budget--;
            if (key_strobe) strobes++;
            if (key_ready) ready_seen++;
        end
        if (m_frames < target) check("frame_timeout", m_frames, target);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; mask = '0; key_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        strobes = 0; ready_seen = 0;
    endtask

    task automatic ack_pulse();
        @(negedge clk); key_ack = 1'b1;
        @(negedge clk); key_ack = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_col",     int'(col), 'hE);
        check("rst_code",    int'(key_code), 0);
        check("rst_ready",   int'(key_ready), 0);
        check("rst_strobe",  int'(key_strobe), 0);
        check("rst_pressed", int'(key_pressed), 0);
        check("rst_hist",    int'(key_hist), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk); rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("col_after8", int'(col), 'hD);
        repeat (24) @(posedge clk);
        #1 check("col_after32", int'(col), 'hE);

        // Key 5 held: single accept, ack, no repeat
        @(negedge clk);
        mask = 16'h0020; strobes = 0;
        wait_frames(2);
        check("k5_strobes", strobes, 1);
        check("k5_code", int'(key_code), 5);
        check("k5_hist", int'(key_hist), 'h0005);
        check("k5_ready", int'(key_ready), 1);
        ack_pulse();
        check("k5_acked", int'(key_ready), 0);
        strobes = 0;
        wait_frames(10);
        check("k5_no_repeat", strobes, 0);

        // Toggle every frame: never stable long enough
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mask = 16'h0020; wait_frames(1);
            mask = 16'h0000; wait_frames(1);
        end
        check("toggle_ready", ready_seen, 0);

        // Chord 1+2, then release 2
        do_reset();
        mask = 16'h0003;
        wait_frames(4);
        check("chord_strobes", strobes, 0);
        mask = 16'h0001; strobes = 0;
        wait_frames(2);
        check("chord_strobes2", strobes, 1);
        check("chord_code", int'(key_code), 1);

        // A, release, D without ack -> overrun
        do_reset();
        mask = 16'h0008;
        wait_frames(2);
        check("a_code", int'(key_code), 'hA);
        mask = 16'h0000;
        wait_frames(2);
        check("a_released", int'(key_pressed), 0);
        mask = 16'h8000;
        wait_frames(2);
        check("d_code", int'(key_code), 'hD);
        check("d_hist", int'(key_hist), 'h00AD);
        check("d_overrun", int'(overrun), 1);
        ack_pulse();
        check("d_ready_clr", int'(key_ready), 0);
        check("d_overrun_clr", int'(overrun), 0);

        // Reset while debouncing a press
        do_reset();
        mask = 16'h0020;
        wait_frames(1);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        #1 check("mid_rst_col", int'(col), 'hE);
        check("mid_rst_pressed", int'(key_pressed), 0);
        @(negedge clk); rst = 1'b0;
        repeat (63) @(posedge clk);
        #1 check("rerun_early", int'(key_strobe), 0);
        @(posedge clk);
        #1 check("rerun_strobe", int'(key_strobe), 1);
        check("rerun_code", int'(key_code), 5);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
